bcd_to_bin_seq: RTL and testbench

//  Sequential BCD-to-binary converter using reverse double-dabble: shift right one bit per cycle, then correct each digit.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_digit_sub3.sv | 12 +
 rtl/bcd_to_bin_seq.sv | 124 ++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants and FSM state type for the BCD<->binary conversion paths.
// The 8/-3 pair serves BCD->binary; the 5/+3 pair serves the binary->BCD display path.
package bcd_pkg;

  localparam int          BCD_DIGIT_W        = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT      = 4'd9;

  localparam logic [3:0]  BCD_ADJ_THRESH     = 4'd8;
  localparam logic [3:0]  BCD_ADJ_VAL        = 4'd3;

  localparam logic [3:0]  BIN2BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0]  BIN2BCD_ADJ_VAL    = 4'd3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_digit_sub3.sv
// Per-digit correction for reverse double-dabble: a digit that reached 8 or more
// after the right shift received a carried-in 8 that must become 5, so subtract 3.
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? digit_i - BCD_ADJ_VAL : digit_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential 4-digit BCD to binary converter (one bit per cycle, start/busy/done).
// Optional `BCD_DIGIT_CHECK_EN adds an err output and short-circuits illegal digits.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       thousands,
  input  logic [3:0]       hundreds,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] binary
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam int                BCD_W    = BCD_DIGIT_W * NUM_DIGITS;
  localparam int                WORK_W   = BCD_W + BIN_W;
  localparam int                CNT_W    = $clog2(BIN_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIN_W - 1);

  state_t              state_q;
  logic [WORK_W-1:0]   work_q;
  logic [WORK_W-1:0]   work_shift;
  logic [WORK_W-1:0]   work_d;
  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W-1:0]    bcd_in;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [BIN_W-1:0]    binary_q;

  assign bcd_in     = BCD_W'({thousands, hundreds, tens, ones});
  assign work_shift = work_q >> 1;

  // All digits are corrected in the same cycle as the shift.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    bcd_digit_sub3 u_sub3 (
      .digit_i (work_shift[BIN_W + gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (bcd_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign work_d = {bcd_adj, work_shift[BIN_W-1:0]};

`ifdef BCD_DIGIT_CHECK_EN
  logic bcd_illegal;
  logic err_pend_q;
  logic err_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bcd_illegal = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) bcd_illegal = 1'b1;
    end
  end

  assign err = err_q;
`endif

  // Outputs are registered from the state, so they trail the FSM by one cycle:
  // busy rises the cycle after accept and covers the done cycle.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      binary_q   <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      busy_q <= (state_q != IDLE);
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            work_q <= {bcd_in, {BIN_W{1'b0}}};
            cnt_q  <= '0;
`ifdef BCD_DIGIT_CHECK_EN
            err_pend_q <= bcd_illegal;
            state_q    <= bcd_illegal ? DONE : SHIFT;
`else
            state_q <= SHIFT;
`endif
          end
        end
        SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_q <= DONE;
        end
        DONE: begin
`ifdef BCD_DIGIT_CHECK_EN
          binary_q <= err_pend_q ? '0 : work_q[BIN_W-1:0];
          err_q    <= err_pend_q;
`else
          binary_q <= work_q[BIN_W-1:0];
`endif
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign binary = binary_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq; latency counted from the accept edge.
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  thousands, hundreds, tens, ones;
  logic        busy, done;
  logic [13:0] binary;
`ifdef BCD_DIGIT_CHECK_EN
  logic        err;
`endif

  int checks   = 0;
  int failures = 0;

  bcd_to_bin_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .busy      (busy),
    .done      (done),
    .binary    (binary)
`ifdef BCD_DIGIT_CHECK_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_digits(input int v);
    thousands = 4'((v / 1000) % 10);
    hundreds  = 4'((v / 100) % 10);
    tens      = 4'((v / 10) % 10);
    ones      = 4'(v % 10);
  endtask

  // Pulse start for one cycle, optionally re-pulse at cycles ign_a/ign_b, and
  // check latency, busy coverage, result and that done is a single pulse.
  task automatic run_conv(input string tag, input logic [3:0] th, input logic [3:0] hu,
                          input logic [3:0] te, input logic [3:0] on, input int exp_bin,
                          input int exp_lat, input logic exp_err, input int ign_a, input int ign_b);
    int k;
    int busy_cnt;
    thousands = th; hundreds = hu; tens = te; ones = on;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    busy_cnt = 0;
    while (!done && k < 40) begin
      if (busy) busy_cnt++;
      start = (k == ign_a || k == ign_b);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({tag, " latency"}, k, exp_lat);
    check({tag, " busy_cycles"}, busy_cnt, exp_lat - 1);
    check({tag, " busy_at_done"}, busy, 1);
    check({tag, " binary"}, binary, exp_bin);
`ifdef BCD_DIGIT_CHECK_EN
    check({tag, " err"}, err, exp_err);
`else
    if (exp_err) $display("note: %s expects err but the check is not built", tag);
`endif
    @(negedge clk);
    check({tag, " done_pulse"}, done, 0);
    check({tag, " busy_off"}, busy, 0);
    check({tag, " binary_held"}, binary, exp_bin);
  endtask

  initial begin
    int ndone;
    int v;
    reset = 1'b1; start = 1'b0;
    thousands = '0; hundreds = '0; tens = '0; ones = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset binary", binary, 0);
`ifdef BCD_DIGIT_CHECK_EN
    check("reset err", err, 0);
`endif

    run_conv("zero", 4'd0, 4'd0, 4'd0, 4'd0, 0,     15, 1'b0, -1, -1);
    run_conv("9999", 4'd9, 4'd9, 4'd9, 4'd9, 9999,  15, 1'b0, -1, -1);
    run_conv("0255", 4'd0, 4'd2, 4'd5, 4'd5, 255,   15, 1'b0, -1, -1);
    run_conv("1024", 4'd1, 4'd0, 4'd2, 4'd4, 1024,  15, 1'b0, -1, -1);
    run_conv("0001", 4'd0, 4'd0, 4'd0, 4'd1, 1,     15, 1'b0, -1, -1);
    run_conv("8888", 4'd8, 4'd8, 4'd8, 4'd8, 8888,  15, 1'b0, -1, -1);

    // Starts while busy are ignored; exactly one done follows.
    run_conv("ignore", 4'd0, 4'd0, 4'd4, 4'd2, 42, 15, 1'b0, 3, 10);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ignore extra_done", ndone, 0);

    // Reset mid-conversion aborts without a done.
    thousands = 4'd5; hundreds = 4'd6; tens = 4'd7; ones = 4'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort binary", binary, 0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no_done", ndone, 0);
    run_conv("after_abort", 4'd0, 4'd0, 4'd0, 4'd7, 7, 15, 1'b0, -1, -1);

    // Start held high, digits change every cycle: accepts at cycles 0,16,32.
    start = 1'b1;
    ndone = 0;
    for (int j = 0; j < 49; j++) begin
      set_digits((j * 613 + 29) % 10000);
      @(negedge clk);
      check($sformatf("b2b done@%0d", j), done, (j % 16) == 15);
      if (done) begin
        ndone++;
        v = ((j - 15) * 613 + 29) % 10000;
        check($sformatf("b2b binary@%0d", j), binary, v);
      end
    end
    start = 1'b0;
    check("b2b done_count", ndone, 3);
    repeat (20) @(negedge clk);

`ifdef BCD_DIGIT_CHECK_EN
    run_conv("illegal", 4'd0, 4'd1, 4'hA, 4'd3, 0,  1,  1'b1, -1, -1);
    run_conv("legal13", 4'd0, 4'd0, 4'd1, 4'd3, 13, 15, 1'b0, -1, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
